// File: rtl/or1200_wb_arb_pkg.sv
// or1200_wb_arb_pkg: shared state, master index and cycle-type constants
// for the OR1200 Wishbone bus arbiter.
package or1200_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_e;

    localparam logic IDX_I = 1'b0;
    localparam logic IDX_D = 1'b1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/or1200_wb_arb_timer.sv
// or1200_wb_arb_timer: watchdog that counts stalled strobe cycles and pulses
// expire on the LIMIT-th consecutive stall.
module or1200_wb_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic clear,
    output logic expire
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        expire = stall & ~clear & (cnt_q == 16'(LIMIT - 1));
        cnt_d  = (clear | ~stall | expire) ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/or1200_wb_bus_arbiter.sv
// or1200_wb_bus_arbiter: round-robin share of one Wishbone slave between the
// OR1200 instruction (0) and data (1) masters; OR1200_WB_ARB_TIMEOUT_EN adds a watchdog.
module or1200_wb_bus_arbiter
    import or1200_wb_arb_pkg::*;
#(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      m_cyc_i,
    input  logic [1:0]      m_stb_i,
    input  logic [1:0]      m_we_i,
    input  logic [7:0]      m_sel_i,
    input  logic [2*AW-1:0] m_adr_i,
    input  logic [2*DW-1:0] m_dat_i,
    input  logic [5:0]      m_cti_i,
    output logic [1:0]      m_ack_o,
    output logic [1:0]      m_err_o,
    output logic [DW-1:0]   m_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [3:0]      s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [2:0]      s_cti_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic [DW-1:0]   s_dat_i
);

    state_e state_q, state_d, idle_pick, hand_off;
    logic   last_grant_q, last_grant_d;
    logic   granted, g, live, expire, ack_bit, err_bit;

    assign granted = state_q != IDLE;
    assign g       = (state_q == GNT_D) ? IDX_D : IDX_I;

`ifdef OR1200_WB_ARB_TIMEOUT_EN
    or1200_wb_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .stall  (granted & m_cyc_i[g] & m_stb_i[g] & ~s_ack_i & ~s_err_i),
        .clear  (~granted),
        .expire (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign expire         = 1'b0;
`endif

    always_comb begin
        idle_pick    = (m_cyc_i == 2'b11) ? (last_grant_q ? GNT_I : GNT_D) :
                       m_cyc_i[1] ? GNT_D : m_cyc_i[0] ? GNT_I : IDLE;
        // Other master takes over directly when the holder drops cyc.
        hand_off     = m_cyc_i[g] ? state_q :
                       m_cyc_i[~g] ? (g ? GNT_I : GNT_D) : IDLE;
        state_d      = expire ? IDLE : granted ? hand_off : idle_pick;
        last_grant_d = (state_d != IDLE && state_d != state_q) ? (state_d == GNT_D) : last_grant_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        live    = granted & ~expire;
        s_cyc_o = live & m_cyc_i[g];
        s_stb_o = live & m_stb_i[g];
        s_we_o  = granted & m_we_i[g];
        s_sel_o = ~granted ? 4'd0 : g ? m_sel_i[7:4] : m_sel_i[3:0];
        s_adr_o = ~granted ? '0 : g ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
        s_dat_o = ~granted ? '0 : g ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
        s_cti_o = ~granted ? 3'd0 : g ? m_cti_i[5:3] : m_cti_i[2:0];
        ack_bit = granted & s_ack_i & ~s_err_i & ~expire;
        err_bit = granted & (s_err_i | expire);
        m_ack_o = {g & ack_bit, ~g & ack_bit};
        m_err_o = {g & err_bit, ~g & err_bit};
        m_dat_o = reset ? '0 : s_dat_i;
    end

endmodule

// File: doc/or1200_wb_bus_arbiter.md
Name: or1200_wb_bus_arbiter

Overview:
- Shares one Wishbone slave port (single unified memory / bus bridge) between the OR1200 instruction master (index 0) and data master (index 1).
- Sits between the CPU wrapper's iwb/dwb ports and the tile's memory/NoC interface.
- Registered round-robin grant, held for the entire Wishbone cycle including bursts.
- Optional watchdog terminates hung transfers with an error.

Parameters:
- DW, 32, data bus width
- AW, 32, address width (word addresses, passed through unmodified)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature; legal range 1..65535

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- m_cyc_i  in  2  cycle valid per master; bit0 = instruction, bit1 = data
- m_stb_i  in  2  strobe per master
- m_we_i  in  2  write enable per master
- m_sel_i  in  8  byte selects; [3:0] = master0, [7:4] = master1
- m_adr_i  in  2*AW  addresses; low AW bits = master0
- m_dat_i  in  2*DW  write data; low DW bits = master0
- m_cti_i  in  6  cycle type identifiers; [2:0] = master0
- m_ack_o  out  2  per-master ack
- m_err_o  out  2  per-master error
- m_dat_o  out  DW  read data, broadcast to both masters
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_sel_o  out  4  slave byte selects
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_cti_o  out  3  slave cycle type
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave error
- s_dat_i  in  DW  slave read data

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - state = IDLE, last_grant = 0.
  - All outputs 0, including every s_* output and m_ack_o/m_err_o.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only m_cyc_i[0] high -> GNT_I.
  - Only m_cyc_i[1] high -> GNT_D.
  - Both high -> grant the master that is not last_grant. After reset, data wins the first tie.
  - last_grant updates on every grant.
- GNT_x, granted master's m_cyc_i stays high -> hold the grant. Bursts (cti 001/010) are never split; an incoming request from the other master waits.
- GNT_x, granted master's m_cyc_i low:
  - Other master's cyc high -> move directly to the other grant state, no IDLE cycle.
  - Otherwise -> IDLE.
- Latency: request first seen in cycle N (arbiter idle) -> s_cyc_o high in cycle N+1. Worst-case handover costs one dead cycle (old cyc low, new grant registered).
- Slave side:
  - s_cyc_o = m_cyc_i[g] in a grant state; s_stb_o = m_stb_i[g] in a grant state.
  - s_we/sel/adr/dat/cti are muxed from the granted master and forced to 0 in IDLE.
  - Muxing is combinational from the registered grant.
- Response routing:
  - m_ack_o[g] = s_ack_i & ~s_err_i; m_err_o[g] = s_err_i.
  - The non-granted bit is always 0, and both bits are 0 in IDLE.
  - s_ack_i and s_err_i high together -> error wins, ack suppressed.
- m_dat_o = s_dat_i unconditionally; masters qualify it with ack.
- No retry support: s_rty is not present, and the masters' rty inputs are tied 0 at the instantiation.

Optional Feature:
- Macro: OR1200_WB_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter increments each cycle s_stb_o is high without s_ack_i/s_err_i.
  - It clears on ack, err, grant change, or IDLE.
  - When it reaches TIMEOUT_CYCLES: m_err_o[g] pulses for 1 cycle, s_cyc_o/s_stb_o are forced 0 that cycle, the counter clears, and the FSM goes to IDLE.
  - A master still holding cyc is re-arbitrated normally.
- Without the macro: no counter logic exists, and m_err_o reflects only s_err_i. A hung slave hangs the bus.

Decomposition:
- Shared package or1200_wb_arb_pkg:
  - State encodings: IDLE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10.
  - Master indices: IDX_I = 0, IDX_D = 1.
  - CTI constants: CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111.
- One sub-module: or1200_wb_arb_timer (watchdog counter plus expiry pulse), instantiated only under OR1200_WB_ARB_TIMEOUT_EN.

Test Plan:
- Single master: m_cyc_i = 2'b01, adr 0x100 at cycle 0 -> s_cyc_o = 1, s_adr_o = 0x100 at cycle 1; slave ack -> m_ack_o = 2'b01, m_dat_o = s_dat_i.
- Tie after reset: m_cyc_i = 2'b11 -> data granted first. When data drops cyc, instruction is granted the next cycle with no IDLE; a subsequent tie grants data.
- Burst hold: instruction 4-beat burst (cti 010,010,010,111) while data requests -> all 4 acks go to bit0 and the data grant occurs only after iwb cyc drops.
- Error priority: s_ack_i = s_err_i = 1 during a data grant -> m_err_o = 2'b10, m_ack_o = 2'b00.
- Mid-transfer reset: assert reset while in GNT_D with stb high -> all s_* outputs and m_ack_o/m_err_o are 0 in the same cycle; after release, state is IDLE.
- With OR1200_WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8: hold stb with no ack -> m_err_o[g] pulses on the 8th stalled cycle, s_cyc_o is 0 that cycle, then IDLE; without the macro, no err ever.
